// File: rtl/text_cursor_loc_ctl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// text_cursor_loc_ctl
// Text-mode character address / row-scan sequencer with cursor detection.
// It tracks the current character address and the scan line inside each text
// row. It also produces the registered cursor attribute bit for the character
// being fetched.
//
// Ports
//   t_crt_clk       CRT clock
//   h_reset         asynchronous reset, active-high
//   c_shift_ld      character-clock enable, one cycle per character
//   c_hde           horizontal display enable
//   c_line_end      pulse at end of each scan line
//   c_frame_start   pulse at start of frame (first displayed line)
//   c_start_addr    display start address (CR0C/CR0D)
//   c_offset        row offset (CR13)
//   c_max_scan      maximum scan line (CR09[4:0])
//   c_cur_start     cursor start scan line (CR0A[4:0])
//   c_cur_end       cursor end scan line (CR0B[4:0])
//   c_cursor_loc    cursor location (CR0E/CR0F)
//   char_addr       current character address
//   row_scan        current scan line within the character row
//   cursor_row_hit  combinational: row_scan lies within cursor start..end
//   m_att_data_b32  registered cursor attribute bit for the current character
// ----------------------------------------------------------------------------
module text_cursor_loc_ctl #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned SCAN_W       = 5,
    parameter int unsigned OFFSET_SHIFT = 1
) (
    input  logic              t_crt_clk,
    input  logic              h_reset,
    input  logic              c_shift_ld,
    input  logic              c_hde,
    input  logic              c_line_end,
    input  logic              c_frame_start,
    input  logic [ADDR_W-1:0] c_start_addr,
    input  logic [7:0]        c_offset,
    input  logic [SCAN_W-1:0] c_max_scan,
    input  logic [SCAN_W-1:0] c_cur_start,
    input  logic [SCAN_W-1:0] c_cur_end,
    input  logic [ADDR_W-1:0] c_cursor_loc,
    output logic [ADDR_W-1:0] char_addr,
    output logic [SCAN_W-1:0] row_scan,
    output logic              cursor_row_hit,
    output logic              m_att_data_b32
);

    logic [ADDR_W-1:0] char_addr_q, char_addr_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [SCAN_W-1:0] row_scan_q,  row_scan_d;
    logic              att_q,       att_d;

    logic [ADDR_W-1:0] step_c;
    logic [ADDR_W-1:0] next_base_c;
    logic              addr_match_c;

    // Per-row address step; offset is in word units, wrap is silent.
    assign step_c       = ADDR_W'(c_offset) << OFFSET_SHIFT;
    assign next_base_c  = line_base_q + step_c;
    assign addr_match_c = (char_addr_q == c_cursor_loc);

    // An inverted start/end window gives no hit, so the cursor is suppressed.
    assign cursor_row_hit = (c_cur_start <= row_scan_q) && (row_scan_q <= c_cur_end);

    // Counter update: frame start beats line end, which beats character advance.
    always_comb begin
        char_addr_d = char_addr_q;
        line_base_d = line_base_q;
        row_scan_d  = row_scan_q;
        att_d       = att_q;

        if (c_frame_start) begin
            line_base_d = c_start_addr;
            char_addr_d = c_start_addr;
            row_scan_d  = '0;
        end else if (c_line_end) begin
            if (row_scan_q == c_max_scan) begin
                row_scan_d  = '0;
                line_base_d = next_base_c;
                char_addr_d = next_base_c;
            end else begin
                // A row_scan above max_scan keeps counting until it wraps to equality.
                row_scan_d  = row_scan_q + SCAN_W'(1);
                char_addr_d = line_base_q;
            end
        end else if (c_shift_ld && c_hde) begin
            char_addr_d = char_addr_q + ADDR_W'(1);
        end

        // The attribute samples the address and scan line from before this cycle's update.
        if (c_shift_ld) begin
            att_d = c_hde && cursor_row_hit && addr_match_c;
        end
    end

    always_ff @(posedge t_crt_clk or posedge h_reset) begin
        if (h_reset) begin
            char_addr_q <= '0;
            line_base_q <= '0;
            row_scan_q  <= '0;
            att_q       <= 1'b0;
        end else begin
            char_addr_q <= char_addr_d;
            line_base_q <= line_base_d;
            row_scan_q  <= row_scan_d;
            att_q       <= att_d;
        end
    end

    assign char_addr      = char_addr_q;
    assign row_scan       = row_scan_q;
    assign m_att_data_b32 = att_q;

endmodule
